// File: rtl/video_pkg.sv
// Shared video constants: pattern mode encodings, RGB888 colours and the
// colour-bar lookup used by the pattern generator.
package video_pkg;

  typedef enum logic [2:0] {
    MODE_BARS  = 3'd0,
    MODE_RAMP  = 3'd1,
    MODE_CHECK = 3'd2,
    MODE_BOX   = 3'd3,
    MODE_SOLID = 3'd4
  } mode_e;

  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

  // Ramp level x>>3, saturated at full scale.
  function automatic logic [7:0] gray_level(input logic [10:0] x);
    logic [10:0] s;
    s = x >> 3;
    return (s > 11'd255) ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/box_mover.sv
// Moving-box position: steps both axes once per frame and bounces off the
// screen edges, clamping to the edge on the frame it is reached.
module box_mover #(
  parameter int H_DISP   = 1280,
  parameter int V_DISP   = 720,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 2
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic        frame_start,
  output logic [10:0] box_x,
  output logic [10:0] box_y
);

  localparam int X_LIM = H_DISP - BOX_SIZE;
  localparam int Y_LIM = V_DISP - BOX_SIZE;

  logic [10:0] r_box_x;
  logic [10:0] r_box_y;
  logic        r_dir_x;
  logic        r_dir_y;

  // Returns {new_dir, new_pos}; dir=1 means moving towards the far edge.
  function automatic logic [11:0] step_axis(input logic [10:0] pos,
                                            input logic        dir,
                                            input int          lim);
    int nxt;
    nxt = dir ? int'(pos) + BOX_STEP : int'(pos) - BOX_STEP;
    if (dir && nxt >= lim)       step_axis = {1'b0, 11'(lim)};
    else if (!dir && nxt <= 0)   step_axis = {1'b1, 11'd0};
    else                         step_axis = {dir, 11'(nxt)};
  endfunction

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      r_box_x <= '0;
      r_box_y <= '0;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (frame_start) begin
      {r_dir_x, r_box_x} <= step_axis(r_box_x, r_dir_x, X_LIM);
      {r_dir_y, r_box_y} <= step_axis(r_box_y, r_dir_y, Y_LIM);
    end
  end

  assign box_x = r_box_x;
  assign box_y = r_box_y;

endmodule

// File: rtl/pattern_gen_multi.sv
// Multi-pattern video test generator: colour bars, gray ramp, checker,
// bouncing box and solid colour, two-stage pipeline from position to pixel.
module pattern_gen_multi
  import video_pkg::*;
#(
  parameter logic [10:0] H_DISP     = 11'd1280,
  parameter logic [10:0] V_DISP     = 11'd720,
  parameter int          BAR_NUM    = 8,
  parameter int          BOX_SIZE   = 64,
  parameter int          BOX_STEP   = 2,
  parameter int          CHECK_LOG2 = 5
) (
  input  logic        pixel_clk,
  input  logic        sys_rst,
  input  logic [10:0] pixel_xpos,
  input  logic [10:0] pixel_ypos,
  input  logic [2:0]  mode_sel,
  input  logic [23:0] solid_rgb,
  output logic [23:0] pixel_data,
  output logic [2:0]  mode_act,
  output logic        frame_start
);

  localparam logic [11:0] BAR_W    = 12'(int'(H_DISP) / BAR_NUM);
  localparam logic [2:0]  BAR_LAST = 3'(BAR_NUM - 1);
  localparam logic [11:0] BOX_W    = 12'(BOX_SIZE);

  logic        w_origin;
  logic        w_frame_hit;
  logic        w_in_box;
  logic [10:0] w_box_x;
  logic [10:0] w_box_y;

  logic        r_prev_origin;
  logic        r_frame_start;
  logic [2:0]  r_mode_act;
  logic [2:0]  r_bar_idx;
  logic [11:0] r_bar_next;
  logic        r_in_disp;
  logic        r_in_box;
  logic        r_check;
  logic [7:0]  r_gray;
  logic [23:0] r_solid;
  logic [23:0] r_pixel;

  assign w_origin    = (pixel_xpos == '0) && (pixel_ypos == '0);
  assign w_frame_hit = w_origin && !r_prev_origin;
  assign w_in_box    = ({1'b0, pixel_xpos} >= {1'b0, w_box_x}) &&
                       ({1'b0, pixel_xpos} <  {1'b0, w_box_x} + BOX_W) &&
                       ({1'b0, pixel_ypos} >= {1'b0, w_box_y}) &&
                       ({1'b0, pixel_ypos} <  {1'b0, w_box_y} + BOX_W);

  box_mover #(
    .H_DISP  (int'(H_DISP)),
    .V_DISP  (int'(V_DISP)),
    .BOX_SIZE(BOX_SIZE),
    .BOX_STEP(BOX_STEP)
  ) u_box (
    .pixel_clk  (pixel_clk),
    .sys_rst    (sys_rst),
    .frame_start(r_frame_start),
    .box_x      (w_box_x),
    .box_y      (w_box_y)
  );

  // Stage 1. The mode is latched together with the frame_start pulse so the
  // first pixel of the frame already renders in the new mode.
  // NOTE: every register here uses <=, so all reads see pre-edge values and
  // the stage ordering does not depend on statement order.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      r_prev_origin <= 1'b0;
      r_frame_start <= 1'b0;
      r_mode_act    <= MODE_BARS;
      r_bar_idx     <= '0;
      r_bar_next    <= BAR_W;
      r_in_disp     <= 1'b0;
      r_in_box      <= 1'b0;
      r_check       <= 1'b0;
      r_gray        <= '0;
      r_solid       <= '0;
    end else begin
      r_prev_origin <= w_origin;
      r_frame_start <= w_frame_hit;
      if (w_frame_hit) r_mode_act <= mode_sel;
      // Bar index tracks the incrementing column, avoiding a divider.
      if (pixel_xpos == '0) begin
        r_bar_idx  <= '0;
        r_bar_next <= BAR_W;
      end else if (({1'b0, pixel_xpos} == r_bar_next) && (r_bar_idx != BAR_LAST)) begin
        r_bar_idx  <= r_bar_idx + 3'd1;
        r_bar_next <= r_bar_next + BAR_W;
      end
      r_in_disp <= (pixel_xpos < H_DISP) && (pixel_ypos < V_DISP);
      r_in_box  <= w_in_box;
      r_check   <= pixel_xpos[CHECK_LOG2] ^ pixel_ypos[CHECK_LOG2];
      r_gray    <= gray_level(pixel_xpos);
      r_solid   <= solid_rgb;
    end
  end

  // Stage 2: colour selection.
  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      r_pixel <= '0;
    end else if (!r_in_disp) begin
      r_pixel <= RGB_BLACK;
    end else begin
      case (r_mode_act)
        MODE_BARS:  r_pixel <= bar_color(r_bar_idx);
        MODE_RAMP:  r_pixel <= {r_gray, r_gray, r_gray};
        MODE_CHECK: r_pixel <= r_check ? RGB_BLACK : RGB_WHITE;
        MODE_BOX:   r_pixel <= r_in_box ? RGB_WHITE : RGB_BLUE;
        MODE_SOLID: r_pixel <= r_solid;
        default:    r_pixel <= RGB_BLACK;
      endcase
    end
  end

  assign pixel_data  = r_pixel;
  assign mode_act    = r_mode_act;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_pattern_gen_multi.sv
// Directed bench for pattern_gen_multi: default 8-bar instance plus a 3-bar
// instance sharing the same stimulus; pixel expectations trail by 2 cycles.
module tb_pattern_gen_multi;

  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] BLUE  = 24'h0000FF;
  localparam logic [23:0] BLACK = 24'h000000;

  logic        pixel_clk = 1'b0;
  logic        sys_rst;
  logic [10:0] pixel_xpos;
  logic [10:0] pixel_ypos;
  logic [2:0]  mode_sel;
  logic [23:0] solid_rgb;
  logic [23:0] pixel_data;
  logic [2:0]  mode_act;
  logic        frame_start;
  logic [23:0] pixel_data3;
  logic [2:0]  mode_act3;
  logic        frame_start3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          chk;
    bit          chk3;
    logic [23:0] exp;
    logic [23:0] exp3;
    string       tag;
  } exp_t;

  exp_t pipe_q[$];

  always #5 pixel_clk = ~pixel_clk;

  pattern_gen_multi dut (
    .pixel_clk  (pixel_clk),
    .sys_rst    (sys_rst),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .mode_sel   (mode_sel),
    .solid_rgb  (solid_rgb),
    .pixel_data (pixel_data),
    .mode_act   (mode_act),
    .frame_start(frame_start)
  );

  pattern_gen_multi #(.BAR_NUM(3)) dut3 (
    .pixel_clk  (pixel_clk),
    .sys_rst    (sys_rst),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .mode_sel   (mode_sel),
    .solid_rgb  (solid_rgb),
    .pixel_data (pixel_data3),
    .mode_act   (mode_act3),
    .frame_start(frame_start3)
  );

  task automatic check(input string tag, input logic [23:0] act, input logic [23:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int idx);
    case (idx)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // One pixel clock: check the pixel applied two ticks ago, then apply (x,y).
  task automatic tick(input int x, input int y, input bit chk, input logic [23:0] exp,
                      input bit chk3, input logic [23:0] exp3, input string tag);
    exp_t e;
    @(posedge pixel_clk);
    #1;
    if (pipe_q.size() == 2) begin
      e = pipe_q.pop_front();
      if (e.chk)  check(e.tag, pixel_data, e.exp);
      if (e.chk3) check({e.tag, " bar3"}, pixel_data3, e.exp3);
    end
    pixel_xpos = 11'(x);
    pixel_ypos = 11'(y);
    e.chk  = chk;
    e.chk3 = chk3;
    e.exp  = exp;
    e.exp3 = exp3;
    e.tag  = $sformatf("%s (%0d,%0d)", tag, x, y);
    pipe_q.push_back(e);
  endtask

  task automatic tick_c(input int x, input int y, input logic [23:0] exp, input string tag);
    tick(x, y, 1'b1, exp, 1'b0, BLACK, tag);
  endtask

  task automatic tick_n(input int x, input int y);
    tick(x, y, 1'b0, BLACK, 1'b0, BLACK, "idle");
  endtask

  initial begin
    sys_rst    = 1'b1;
    pixel_xpos = 11'd5;
    pixel_ypos = 11'd5;
    mode_sel   = 3'd0;
    solid_rgb  = 24'h123456;

    // Reset state
    repeat (3) tick_n(5, 5);
    check("rst pixel_data", pixel_data, BLACK);
    check("rst mode_act", 24'(mode_act), 24'd0);
    check("rst frame_start", 24'(frame_start), 24'd0);
    check("rst box_x", 24'(dut.w_box_x), 24'd0);
    check("rst box_y", 24'(dut.w_box_y), 24'd0);
    sys_rst = 1'b0;
    tick_n(5, 5);

    // Full bar line, 8 bars and 3 bars
    for (int x = 0; x < 1280; x++) begin
      tick(x, 0, 1'b1, bar_rgb(x / 160), 1'b1,
           bar_rgb(x < 426 ? 0 : (x < 852 ? 1 : 2)), "bars");
      if (x == 1) check("frame_start pulse", 24'(frame_start), 24'd1);
      if (x == 2) check("frame_start single", 24'(frame_start), 24'd0);
    end
    tick_n(5, 5);
    tick_n(5, 5);

    // Mode change mid-frame is deferred to the next frame
    for (int x = 0; x <= 40; x++) begin
      tick_c(x, 300, WHITE, "bars row300");
      if (x == 10) mode_sel = 3'd2;
    end
    check("mode held midframe", 24'(mode_act), 24'd0);
    tick_n(5, 300);
    tick_c(0, 0, WHITE, "checker origin");
    for (int x = 1; x <= 40; x++) begin
      tick_c(x, 0, (x < 32) ? WHITE : BLACK, "checker row0");
      if (x == 1) check("mode switched", 24'(mode_act), 24'd2);
    end
    tick_c(32, 32, WHITE, "checker 32,32");
    tick_c(31, 32, BLACK, "checker 31,32");
    tick_c(1300, 10, BLACK, "blank x1300");
    tick_c(10, 720, BLACK, "blank y720");
    tick_c(1280, 719, BLACK, "blank x1280");

    // Gray ramp
    mode_sel = 3'd1;
    tick_n(5, 5);
    tick_c(0, 0, 24'h000000, "ramp x0");
    tick_c(8, 5, 24'h010101, "ramp x8");
    tick_c(1279, 5, 24'h9F9F9F, "ramp x1279");
    tick_c(1000, 719, 24'h7D7D7D, "ramp x1000");
    tick_c(1000, 720, BLACK, "ramp blank");

    // Solid colour, sampled with the pixel
    mode_sel = 3'd4;
    tick_n(5, 5);
    tick_c(0, 0, 24'h123456, "solid a");
    tick_c(1, 0, 24'hA5C3E1, "solid b");
    solid_rgb = 24'hA5C3E1;
    tick_c(2, 0, 24'hA5C3E1, "solid b2");
    check("mode solid", 24'(mode_act), 24'd4);
    tick_c(1300, 0, BLACK, "solid blank");

    // Reserved mode
    mode_sel = 3'd6;
    tick_n(5, 5);
    tick_c(0, 0, BLACK, "reserved origin");
    tick_c(100, 100, BLACK, "reserved 100");
    check("mode reserved", 24'(mode_act), 24'd6);
    tick_n(5, 5);
    tick_n(5, 5);

    // Box bounce over 640 short frames from a fresh reset
    sys_rst = 1'b1;
    tick_n(5, 5);
    tick_n(5, 5);
    sys_rst  = 1'b0;
    mode_sel = 3'd3;
    for (int f = 1; f <= 640; f++) begin
      tick_n(0, 0);
      tick_n(1, 0);
      tick_n(2, 0);
      if (f == 328) check("box_y at limit", 24'(dut.w_box_y), 24'd656);
      if (f == 329) check("box_y reversed", 24'(dut.w_box_y), 24'd654);
      if (f == 608) check("box_x at limit", 24'(dut.w_box_x), 24'd1216);
      if (f == 609) check("box_x reversed", 24'(dut.w_box_x), 24'd1214);
      if (f == 640) begin
        check("box_x f640", 24'(dut.w_box_x), 24'd1152);
        check("box_y f640", 24'(dut.w_box_y), 24'd32);
      end
    end
    tick_c(1151, 32, BLUE, "box left out");
    tick_c(1152, 32, WHITE, "box corner");
    tick_c(1215, 95, WHITE, "box far corner");
    tick_c(1216, 40, BLUE, "box right out");
    tick_c(1160, 31, BLUE, "box top out");
    tick_c(1160, 96, BLUE, "box bottom out");
    tick_c(1300, 40, BLACK, "box blank");
    check("mode box", 24'(mode_act), 24'd3);

    // Reset pulsed mid-frame
    tick_n(499, 400);
    tick_n(500, 400);
    sys_rst = 1'b1;
    tick_n(501, 400);
    check("midrst pixel_data", pixel_data, BLACK);
    check("midrst mode_act", 24'(mode_act), 24'd0);
    check("midrst box_x", 24'(dut.w_box_x), 24'd0);
    check("midrst box_y", 24'(dut.w_box_y), 24'd0);
    sys_rst = 1'b0;
    tick_c(0, 5, WHITE, "post-rst bars");
    tick_n(1, 5);
    check("post-rst mode", 24'(mode_act), 24'd0);
    tick_n(2, 5);
    tick_n(0, 0);
    tick_n(1, 0);
    tick_n(2, 0);
    check("post-rst mode loaded", 24'(mode_act), 24'd3);
    check("post-rst box_x", 24'(dut.w_box_x), 24'd2);
    check("post-rst box_y", 24'(dut.w_box_y), 24'd2);
    tick_n(3, 0);
    tick_n(4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_gen_multi.md
PATTERN_GEN_MULTI -- requirements
Module: pattern_gen_multi

Interface
REQ-001 The block SHALL expose parameter H_DISP, default 11'd1280, active pixels per line.
REQ-002 The block SHALL expose parameter V_DISP, default 11'd720, active lines per frame.
REQ-003 The block SHALL expose parameter BAR_NUM, default 8, colour-bar count (legal 2..8).
REQ-004 The block SHALL expose parameter BOX_SIZE, default 64, moving-box edge in pixels, and BOX_STEP, default 2, box pixels moved per frame per axis.
REQ-005 The block SHALL expose parameter CHECK_LOG2, default 5, checker square edge = 2^CHECK_LOG2 pixels.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 Port: pixel_clk  input  1  pixel clock, all logic on rising edge.
REQ-008 Port: sys_rst  input  1  synchronous active-high reset.
REQ-009 Port: pixel_xpos  input  11  current pixel column from the timing driver.
REQ-010 Port: pixel_ypos  input  11  current pixel row from the timing driver.
REQ-011 Port: mode_sel  input  3  requested pattern (0 bars, 1 gray ramp, 2 checker, 3 moving box, 4 solid, 5-7 reserved).
REQ-012 Port: solid_rgb  input  24  RGB888 colour for mode 4.
REQ-013 Port: pixel_data  output  24  RGB888 pixel, registered.
REQ-014 Port: mode_act  output  3  mode currently rendered.
REQ-015 Port: frame_start  output  1  one-cycle pulse at first pixel of each frame.

Function
REQ-016 pixel_xpos SHALL be treated as incrementing by 1 per pixel_clk within a line and returning to 0 at line start; the block SHALL rely on this.
REQ-017 Pipeline: stage 1 registers x, y, bar index, region flags; stage 2 registers pixel_data; latency from pixel_xpos/ypos to pixel_data SHALL be exactly 2 cycles.
REQ-018 frame_start SHALL assert for one cycle, 1 cycle after the input cycle where x==0 && y==0 and the previous cycle was not x==0 && y==0.
REQ-019 mode_act SHALL load mode_sel only on the cycle frame_start asserts; mode_sel changes mid-frame SHALL not affect the current frame.
REQ-020 Bar width BAR_W = H_DISP/BAR_NUM (integer); remainder columns SHALL belong to the last bar.
REQ-021 Bar index SHALL be a counter: cleared when x==0, incremented when x reaches next boundary (k*BAR_W) while index < BAR_NUM-1; no divider in the pixel path.
REQ-022 Bar colours in index order: white, yellow, cyan, green, magenta, red, blue, black; only the first BAR_NUM used.
REQ-023 Mode 1: R=G=B=min(x>>3, 255).
REQ-024 Mode 2: white when x[CHECK_LOG2]^y[CHECK_LOG2]==0, else black.
REQ-025 Mode 3: white inside box [box_x, box_x+BOX_SIZE) x [box_y, box_y+BOX_SIZE), blue elsewhere.
REQ-026 Box position SHALL update once per frame on frame_start: coordinate += or -= BOX_STEP per its direction bit; when the result would pass 0 or H_DISP-BOX_SIZE (V_DISP-BOX_SIZE for y) it SHALL clamp to that limit and invert direction.
REQ-027 Mode 4: solid_rgb, sampled in stage 1.
REQ-028 Modes 5-7 and any pixel with x>=H_DISP or y>=V_DISP SHALL output 24'h000000.

Reset
REQ-029 While sys_rst high: pixel_data=0, mode_act=0, frame_start=0, bar index=0, box_x=box_y=0, both directions positive, pipeline flags cleared.
REQ-030 Reset asserted mid-frame SHALL take effect on the next edge; after release the mode SHALL remain 0 until the next frame_start.

Structure
REQ-031 Bar colour table, RGB888 colour constants and mode encodings SHALL live in shared package video_pkg.
REQ-032 Box position/bounce logic SHALL be sub-module box_mover (inputs frame_start; outputs box_x, box_y).

Verification
REQ-033 Mode 0, defaults, full 1280x720 line: pixel_data white for x 0..159, yellow 160..319, ..., black 1120..1279, each 2 cycles after input.
REQ-034 BAR_NUM=3, H_DISP=1280: bars white 0..425, yellow 426..851, cyan 852..1279.
REQ-035 mode_sel 0->2 at row 300: bars until frame end; checker from next frame_start; pixel (32,0) black, (32,32) white.
REQ-036 Mode 3, 640 frames: box_x reaches 1216 at frame 608, then decreases by 2; box_y clamps at 656 and reverses.
REQ-037 x=1300 or y=720 in any mode -> 24'h000000; mode_sel=6 -> 24'h000000.
REQ-038 sys_rst pulsed at (500,400) in mode 3 -> pixel_data 0 next cycle, mode_act 0, box at (0,0) after release.
